// File: rtl/avr_addr_sequencer.sv
// Serial-load SRAM address sequencer: shifts an address in from the AVR, latches it,
// then advances it on AVR count strobes. Optional AVR_ADDR_AUTO_INC_EN adds oe/we increments.
module avr_addr_sequencer #(
  parameter int unsigned           ADDR_WIDTH = 21,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  avr_clk,
  input  logic                  avr_reset,
  input  logic                  avr_si,
  input  logic                  avr_sreg_en,
  input  logic                  avr_counter,
  input  logic                  avr_oe,
  input  logic                  avr_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  addr_valid,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int unsigned CW = $clog2(ADDR_WIDTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(ADDR_WIDTH);

  typedef enum logic [1:0] {
    ST_SHIFT,
    ST_LOAD,
    ST_RUN
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   shreg;
  logic [CW-1:0]           bitcnt;
  logic                    cnt_prev;
  logic                    cnt_fall;
  logic                    inc_req;

  assign cnt_fall = cnt_prev & ~avr_counter;

`ifdef AVR_ADDR_AUTO_INC_EN
  logic oe_prev;
  logic we_prev;

  // End of an access (strobe rising) counts like a count strobe; coincident sources merge to one step.
  always_comb begin
    inc_req = cnt_fall | (~oe_prev & avr_oe) | (~we_prev & avr_we);
  end

  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      oe_prev <= 1'b1;
      we_prev <= 1'b1;
    end else begin
      oe_prev <= avr_oe;
      we_prev <= avr_we;
    end
  end
`else
  logic unused_strobes;

  assign unused_strobes = ^{avr_oe, avr_we};

  always_comb begin
    inc_req = cnt_fall;
  end
`endif

  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      state      <= ST_SHIFT;
      shreg      <= '0;
      bitcnt     <= '0;
      sram_addr  <= RESET_ADDR;
      addr_valid <= 1'b0;
      wrap       <= 1'b0;
      load_err   <= 1'b0;
      cnt_prev   <= 1'b1;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      // History tracks every cycle so the first RUN cycle sees a true edge, not a stale one.
      cnt_prev <= avr_counter;
      case (state)
        ST_SHIFT: begin
          if (avr_sreg_en) begin
            state <= ST_LOAD;
          end else begin
            shreg <= {shreg[ADDR_WIDTH-2:0], avr_si};
            if (bitcnt != FULL_COUNT) begin
              bitcnt <= bitcnt + CW'(1);
            end
          end
        end
        ST_LOAD: begin
          sram_addr  <= shreg;
          load_err   <= (bitcnt < FULL_COUNT);
          addr_valid <= 1'b1;
          state      <= ST_RUN;
        end
        ST_RUN: begin
          if (!avr_sreg_en) begin
            state      <= ST_SHIFT;
            shreg      <= '0;
            bitcnt     <= '0;
            addr_valid <= 1'b0;
          end else if (inc_req) begin
            sram_addr <= sram_addr + ADDR_WIDTH'(1);
            wrap      <= &sram_addr;
          end
        end
        default: begin
          state <= ST_SHIFT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avr_addr_sequencer.sv
// Bench for avr_addr_sequencer: directed scenarios plus random traffic, checked every
// cycle against a bit-queue reference model.
module tb_avr_addr_sequencer;

  localparam int unsigned W = 21;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         si = 1'b0;
  logic         sreg_en = 1'b0;
  logic         counter = 1'b1;
  logic         oe = 1'b1;
  logic         we = 1'b1;
  logic [W-1:0] sram_addr;
  logic         addr_valid;
  logic         wrap;
  logic         load_err;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] m_addr;
  bit           m_valid, m_wrap, m_err;
  bit           q[$];
  bit           m_running, m_loading;
  bit           p_cnt, p_oe, p_we;

  avr_addr_sequencer #(.ADDR_WIDTH(W), .RESET_ADDR('0)) dut (
    .avr_clk     (clk),
    .avr_reset   (rst),
    .avr_si      (si),
    .avr_sreg_en (sreg_en),
    .avr_counter (counter),
    .avr_oe      (oe),
    .avr_we      (we),
    .sram_addr   (sram_addr),
    .addr_valid  (addr_valid),
    .wrap        (wrap),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] queue_value();
    logic [W-1:0] v = '0;
    foreach (q[i]) v = (v << 1) | W'(q[i]);
    return v;
  endfunction

  task automatic model_edge();
    bit inc;
    if (rst) begin
      m_addr = '0; m_valid = 0; m_wrap = 0; m_err = 0;
      q.delete(); m_running = 0; m_loading = 0;
      p_cnt = 1; p_oe = 1; p_we = 1;
      return;
    end
    m_wrap = 0;
    m_err  = 0;
    inc = p_cnt && !counter;
`ifdef AVR_ADDR_AUTO_INC_EN
    inc = inc || (!p_oe && oe) || (!p_we && we);
`endif
    if (m_loading) begin
      m_addr    = queue_value();
      m_err     = (q.size() < W);
      m_valid   = 1;
      m_loading = 0;
      m_running = 1;
    end else if (m_running) begin
      if (!sreg_en) begin
        m_running = 0;
        m_valid   = 0;
        q.delete();
      end else if (inc) begin
        m_wrap = (m_addr == {W{1'b1}});
        m_addr = W'((64'(m_addr) + 64'd1) % (64'd1 << W));
      end
    end else begin
      if (sreg_en) m_loading = 1;
      else begin
        q.push_back(si);
        if (q.size() > W) void'(q.pop_front());
      end
    end
    p_cnt = counter; p_oe = oe; p_we = we;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("sram_addr", 32'(sram_addr), 32'(m_addr));
    chk("addr_valid", 32'(addr_valid), 32'(m_valid));
    chk("wrap", 32'(wrap), 32'(m_wrap));
    chk("load_err", 32'(load_err), 32'(m_err));
  endtask

  task automatic shift_bits(input logic [31:0] value, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      si = value[i];
      step();
    end
  endtask

  // Leaves RUN (if there), shifts n bits, raises sreg_en and waits through LOAD.
  task automatic load_addr(input logic [31:0] value, input int n);
    sreg_en = 1'b0;
    step();
    shift_bits(value, n);
    sreg_en = 1'b1;
    si = 1'b1;
    step();
    step();
  endtask

  initial begin
    logic [31:0] v;

    step();
    step();
    rst = 1'b0;
    chk("reset_addr", 32'(sram_addr), 32'h0);
    chk("reset_valid", 32'(addr_valid), 32'h0);

    load_addr(32'h0A5F3C, W);
    chk("full_load_addr", 32'(sram_addr), 32'h0A5F3C);
    chk("full_load_valid", 32'(addr_valid), 32'h1);
    chk("full_load_err", 32'(load_err), 32'h0);

    counter = 1'b0; step(); counter = 1'b1; step();
    counter = 1'b0; repeat (5) step(); counter = 1'b1; step();
    counter = 1'b0; step(); counter = 1'b1; step();
    chk("three_incs", 32'(sram_addr), 32'h0A5F3F);

    load_addr(32'h4CCF, 15);
    chk("short_load_addr", 32'(sram_addr), 32'h004CCF);
    chk("short_load_err", 32'(load_err), 32'h1);
    step();
    chk("short_load_err_drop", 32'(load_err), 32'h0);

    load_addr(32'h1FFFFF, W);
    counter = 1'b0; step();
    chk("wrap_addr", 32'(sram_addr), 32'h0);
    chk("wrap_pulse", 32'(wrap), 32'h1);
    counter = 1'b1; step();
    chk("wrap_drop", 32'(wrap), 32'h0);

    load_addr(32'h000100, W);
    oe = 1'b0; step(); step(); oe = 1'b1; step();
`ifdef AVR_ADDR_AUTO_INC_EN
    chk("oe_alone", 32'(sram_addr), 32'h000101);
`else
    chk("oe_alone", 32'(sram_addr), 32'h000100);
`endif
    oe = 1'b0; step(); step(); oe = 1'b1; counter = 1'b0; step();
    counter = 1'b1; step();
`ifdef AVR_ADDR_AUTO_INC_EN
    chk("oe_and_cnt", 32'(sram_addr), 32'h000102);
`else
    chk("oe_and_cnt", 32'(sram_addr), 32'h000101);
`endif

    counter = 1'b0; rst = 1'b1; step();
    chk("rst_run_addr", 32'(sram_addr), 32'h0);
    chk("rst_run_valid", 32'(addr_valid), 32'h0);
    chk("rst_run_wrap", 32'(wrap), 32'h0);
    rst = 1'b0; counter = 1'b1;
    v = 32'($urandom_range(0, (1 << W) - 1));
    load_addr(v, W);
    chk("reload_after_rst", 32'(sram_addr), v);

    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 199) == 0);
      si      = 1'($urandom);
      if ($urandom_range(0, 24) == 0) sreg_en = ~sreg_en;
      if ($urandom_range(0, 2) == 0) counter = ~counter;
      if ($urandom_range(0, 3) == 0) oe = ~oe;
      if ($urandom_range(0, 3) == 0) we = ~we;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
